// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch entry layout, NOP encoding and
// the base opcodes the decoder and fetch queue agree on.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [6:0] opcode_of(input logic [XLEN-1:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Circular fetch-to-decode instruction buffer with valid/ready on both sides
// and single-cycle flush. Define IFQ_BYPASS_EN for empty-queue bypass.
module inst_fetch_queue #(
    parameter int          DEPTH     = 8,
    parameter int          PTR_W     = $clog2(DEPTH),
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [PTR_W:0]   count
);

    import riscv_pkg::*;

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = (PTR_W)'(1);

    fetch_entry_t       mem [DEPTH];
    fetch_entry_t       head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     occ;
    logic               empty;
    logic               full;
    logic               bypass;
    logic               push;
    logic               pop;

    assign empty    = (occ == '0);
    assign full     = (occ == FULL_COUNT);
    assign in_ready = ~full;
    assign count    = occ;

`ifdef IFQ_BYPASS_EN
    assign bypass = empty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry that the decoder takes immediately is never stored.
    assign out_valid = ~empty | bypass;
    assign pop       = ~empty & out_ready;
    assign push      = in_valid & ~full & ~(bypass & out_ready);

    always_comb begin
        head = mem[rd_ptr];
        if (bypass) begin
            head = {in_pc, in_instr};
        end else if (empty) begin
            head = {32'h0, NOP_INSTR};
        end
    end

    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occ <= occ + CNT_ONE;
                2'b01:   occ <= occ - CNT_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // Storage carries no reset; stale contents are masked by the occupancy.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr] <= {in_pc, in_instr};
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized self-checking bench for inst_fetch_queue against a queue-based
// reference model; follows IFQ_BYPASS_EN when it is defined.
module tb_inst_fetch_queue;

    localparam int          DEPTH = 8;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [3:0]  count;

    int   checkCount = 0;
    int   errorCount = 0;
    ent_t modelQ[$];

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected combinational outputs derived from the model and current inputs.
    task automatic checkModel();
        int   sz = modelQ.size();
        bit   byp = 1'b0;
        ent_t hd;
`ifdef IFQ_BYPASS_EN
        byp = (sz == 0) && in_valid && !flush;
`endif
        hd.pc    = 32'h0;
        hd.instr = NOP;
        if (byp) begin
            hd.pc    = in_pc;
            hd.instr = in_instr;
        end else if (sz != 0) begin
            hd = modelQ[0];
        end
        checkOutput("count", 32'(count), 32'(sz));
        checkOutput("in_ready", 32'(in_ready), 32'(sz != DEPTH));
        checkOutput("out_valid", 32'(out_valid), 32'((sz != 0) || byp));
        checkOutput("out_pc", out_pc, hd.pc);
        checkOutput("out_instr", out_instr, hd.instr);
    endtask

    task automatic updateModel();
        int sz = modelQ.size();
        bit byp = 1'b0;
        bit popIt;
        bit pushIt;
        ent_t e;
        if (rst || flush) begin
            modelQ.delete();
        end else begin
`ifdef IFQ_BYPASS_EN
            byp = (sz == 0) && in_valid;
`endif
            popIt  = (sz != 0) && out_ready;
            pushIt = in_valid && (sz != DEPTH) && !(byp && out_ready);
            if (popIt) void'(modelQ.pop_front());
            if (pushIt) begin
                e.pc    = in_pc;
                e.instr = in_instr;
                modelQ.push_back(e);
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic ordy, input logic [31:0] p,
                                 input logic [31:0] ins);
        @(negedge clk);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        out_ready = ordy;
        in_pc     = p;
        in_instr  = ins;
        #1;
        checkModel();
        @(posedge clk);
        updateModel();
    endtask

    task automatic idleDrive();
        @(negedge clk);
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
    endtask

    task automatic pushN(input int n, input logic [31:0] basePc);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, basePc + 32'(4 * k), $urandom);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = 32'h0; in_instr = 32'h0;
        repeat (2) @(posedge clk);
        modelQ.delete();

        // Reset state
        idleDrive();
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_out_instr", out_instr, NOP);

        // Three pushes with the decoder stalled
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h00500093);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h00a00113);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h002081b3);
        idleDrive();
        checkOutput("p3_count", 32'(count), 32'd3);
        checkOutput("p3_out_pc", out_pc, 32'h0);
        checkOutput("p3_out_instr", out_instr, 32'h00500093);
        checkOutput("p3_in_ready", 32'(in_ready), 32'd1);

        // Fill to DEPTH, reject a ninth push, drain in order
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        pushN(DEPTH, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'hdeadbeef);
        idleDrive();
        checkOutput("full_count", 32'(count), 32'd7);
        checkOutput("full_head", out_pc, 32'h4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        pushN(DEPTH, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'hdeadbeef);
        idleDrive();
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("full_count8", 32'(count), 32'd8);
        for (int k = 0; k < DEPTH; k++) begin
            idleDrive();
            checkOutput("drain_pc", out_pc, 32'(4 * k));
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        end
        idleDrive();
        checkOutput("drain_empty", 32'(out_valid), 32'd0);

        // Steady stream: occupancy constant while pointers wrap twice
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        pushN(2, 32'h200);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h208 + 32'(4 * k), $urandom);
        end
        idleDrive();
        checkOutput("stream_count", 32'(count), 32'd2);
        checkOutput("stream_head", out_pc, 32'h250);

        // Flush at count=5 with a concurrent push and pop
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        pushN(5, 32'h500);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h600, 32'h00100073);
        idleDrive();
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_out_instr", out_instr, NOP);

        // Reset mid-stream at count=4, then a fresh push reaches the head
        pushN(4, 32'h700);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        idleDrive();
        checkOutput("mrst_count", 32'(count), 32'd0);
        checkOutput("mrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mrst_out_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h00000537);
        idleDrive();
        checkOutput("mrst_head", out_pc, 32'h300);
        checkOutput("mrst_count1", 32'(count), 32'd1);

`ifdef IFQ_BYPASS_EN
        // Same-cycle forwarding on an empty queue
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h400; in_instr = 32'h123450b7;
        #1;
        checkOutput("byp_out_valid", 32'(out_valid), 32'd1);
        checkOutput("byp_out_instr", out_instr, 32'h123450b7);
        checkOutput("byp_count", 32'(count), 32'd0);
        @(posedge clk);
        updateModel();
        idleDrive();
        checkOutput("byp_count_after", 32'(count), 32'd0);
`endif

        // Randomized traffic with occasional flush and reset
        for (int k = 0; k < 600; k++) begin
            int ordyPct = ((k / 100) % 2 == 0) ? 30 : 80;
            applyStimulus(($urandom_range(99) < 2) ? 1'b1 : 1'b0,
                          ($urandom_range(99) < 4) ? 1'b1 : 1'b0,
                          ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
                          ($urandom_range(99) < ordyPct) ? 1'b1 : 1'b0,
                          $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Circular instruction buffer between the fetch unit and the instruction decoder.
- Decouples fetch bandwidth from decode/dispatch stalls using valid/ready handshakes on both sides.
- Supports a single-cycle pipeline flush on branch mispredict.
- Presents the head {pc, instruction} pair to the decoder, which consumes it combinationally.

Parameters:
- DEPTH, 8, number of entries; must be a power of two, minimum 2.
- PTR_W, $clog2(DEPTH), read/write pointer width.
- NOP_INSTR, 32'h00000013, instruction driven on out_instr while empty (addi x0,x0,0).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries (mispredict/exception).
- in_valid  input  1  fetch presents an entry.
- in_ready  output  1  queue can accept an entry this cycle.
- in_pc  input  32  PC of the fetched instruction.
- in_instr  input  32  raw 32-bit instruction word.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode/dispatch accepts head this cycle.
- out_pc  output  32  PC of head entry.
- out_instr  output  32  instruction word of head entry; goes to the decoder's instruction input.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, in_ready=1, out_pc=0, out_instr=NOP_INSTR.
  - Storage array contents are don't-care.
  - Reset has priority over flush, push and pop; asserting it mid-stream drops all entries.
- Push = in_valid & in_ready. Writes {in_pc,in_instr} at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- Pop = out_valid & out_ready. rd_ptr increments modulo DEPTH.
- in_ready = (count != DEPTH). Combinational from count only; does not depend on out_ready. A full queue never accepts a push, even if a pop occurs in the same cycle.
- out_valid = (count != 0).
- out_pc/out_instr: combinational read of the array at rd_ptr. When empty, they read 0 and NOP_INSTR.
- Latency: an entry pushed in cycle N is visible on outputs in cycle N+1 (without bypass).
- count update:
  - push-only: +1.
  - pop-only: -1.
  - push and pop together: unchanged.
- Simultaneous push and pop at count=1: the old head pops and the new entry becomes head next cycle. Order is preserved.
- Flush:
  - At the next edge, count=0 and wr_ptr=rd_ptr=0.
  - Any same-cycle push and pop are ignored.
  - out_valid=0 from the following cycle.
  - in_ready stays combinationally computed, so a push offered during flush is lost. Fetch must redirect.
- Ordering: strict FIFO. No reordering or entry skipping.
- Wrap-around: pointers wrap DEPTH-1 -> 0 without a bubble. Full is distinguished from empty via count.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- With the macro defined, when count=0, in_valid=1 and flush=0:
  - in_pc/in_instr are forwarded combinationally to the outputs and out_valid=1 in the same cycle.
  - If out_ready=1, the entry is consumed and not written; count stays 0.
  - If out_ready=0, the entry is written normally.
- Without the macro, empty-queue latency is 1 cycle and out_valid never depends combinationally on in_valid.

Decomposition:
- Shared package (riscv_pkg), containing:
  - NOP_INSTR constant.
  - XLEN=32.
  - fetch entry struct {pc[31:0], instr[31:0]}.
  - Opcode constants (OP_IMM 0010011, LOAD 0000011, STORE 0100011, LUI 0110111), shared with the decoder.
- Sub-module: none required. Pointer/count logic and the storage array live in one module. The decoder is instantiated by the parent stage, not inside this block.

Test Plan:
- Reset, then push 8'd3 entries (pc 0x0,0x4,0x8; instr 0x00500093,0x00a00113,0x002081b3) with out_ready=0 -> count=3, out_pc=0x0, out_instr=0x00500093, in_ready=1.
- Fill DEPTH=8 with out_ready=0 -> in_ready=0 at count=8. A ninth push is ignored. Draining returns pc 0x0..0x1C in order.
- Steady stream with in_valid=out_ready=1 for 20 cycles -> count constant, pointers wrap twice, no lost or duplicated pc.
- At count=5, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, out_instr=0x00000013.
- Assert rst mid-stream at count=4 -> next cycle count=0, in_ready=1, out_valid=0. The next push appears at head.
- With IFQ_BYPASS_EN, empty queue, in_valid=1, out_ready=1, in_instr=0x123450b7 -> out_valid=1 in the same cycle with out_instr=0x123450b7, and count stays 0.
